// File: rtl/alu_pkg.sv
// Shared types for the 4-bit ALU checker: opcodes, flag bundle, checker states
// and the bit positions of the mismatch mask.
package alu_pkg;

    typedef enum logic [1:0] {
        ADD = 2'b00,
        SUB = 2'b01,
        AND = 2'b10,
        OR  = 2'b11
    } alu_op_e;

    typedef struct packed {
        logic zero;
        logic carry;
        logic sign;
        logic parity;
        logic overflow;
    } alu_flags_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        FAIL = 2'd2,
        HALT = 2'd3
    } chk_state_e;

    localparam int MASK_RESULT   = 0;
    localparam int MASK_ZERO     = 1;
    localparam int MASK_CARRY    = 2;
    localparam int MASK_SIGN     = 3;
    localparam int MASK_PARITY   = 4;
    localparam int MASK_OVERFLOW = 5;
    localparam int MASK_W        = 6;

endpackage

// File: rtl/alu_ref_model.sv
// Combinational golden model of the 4-bit ALU: result and flags from a, b, select.
module alu_ref_model
    import alu_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [1:0] select,
    output logic [3:0] result,
    output alu_flags_t flags
);

    logic [4:0] wide;
    logic       carry;
    logic       overflow;

    // Subtraction borrows into bit 4, so wide[4] doubles as the borrow flag.
    always_comb begin
        wide     = 5'd0;
        carry    = 1'b0;
        overflow = 1'b0;
        case (alu_op_e'(select))
            ADD: begin
                wide     = {1'b0, a} + {1'b0, b};
                carry    = wide[4];
                overflow = (a[3] == b[3]) && (wide[3] != a[3]);
            end
            SUB: begin
                wide     = {1'b0, a} - {1'b0, b};
                carry    = wide[4];
                overflow = (a[3] != b[3]) && (wide[3] != a[3]);
            end
            AND:     wide = {1'b0, a & b};
            OR:      wide = {1'b0, a | b};
            default: wide = 5'd0;
        endcase
    end

    assign result         = wide[3:0];
    assign flags.zero     = (wide[3:0] == 4'd0);
    assign flags.carry    = carry;
    assign flags.sign     = wide[3];
    assign flags.parity   = ^wide[3:0];
    assign flags.overflow = overflow;

endmodule

// File: rtl/alu_checker.sv
// Two-stage self-checking monitor for the 4-bit ALU with saturating statistics.
// Define ALU_CHK_FIRST_ERR_EN to add capture ports for the first failing transaction.
module alu_checker
    import alu_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       a,
    input  logic [3:0]       b,
    input  logic [1:0]       select,
    input  logic [3:0]       out,
    input  logic             zero,
    input  logic             carry,
    input  logic             sign,
    input  logic             parity,
    input  logic             overflow,
    output logic [CNT_W-1:0] txn_count,
    output logic [CNT_W-1:0] err_count,
    output logic             err_flag,
    output logic [5:0]       last_mask,
`ifdef ALU_CHK_FIRST_ERR_EN
    output logic [3:0]       first_a,
    output logic [3:0]       first_b,
    output logic [1:0]       first_sel,
    output logic [3:0]       first_out,
    output logic [3:0]       first_exp,
    output logic [5:0]       first_mask,
    output logic [CNT_W-1:0] first_idx,
`endif
    output logic [1:0]       state
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    chk_state_e      cur_state;
    logic            transfer;
    logic [3:0]      ref_out;
    alu_flags_t      ref_flags;
    alu_flags_t      in_flags;

    logic            s1_valid;
    logic [3:0]      s1_out;
    logic [3:0]      s1_exp_out;
    alu_flags_t      s1_flags;
    alu_flags_t      s1_exp_flags;
`ifdef ALU_CHK_FIRST_ERR_EN
    logic [3:0]      s1_a;
    logic [3:0]      s1_b;
    logic [1:0]      s1_sel;
`endif

    logic [MASK_W-1:0] mismatch;
    logic              is_err;

    assign in_ready = (cur_state != HALT) && !clear;
    assign transfer = in_valid && in_ready;
    assign state    = cur_state;

    assign in_flags.zero     = zero;
    assign in_flags.carry    = carry;
    assign in_flags.sign     = sign;
    assign in_flags.parity   = parity;
    assign in_flags.overflow = overflow;

    alu_ref_model u_ref (
        .a      (a),
        .b      (b),
        .select (select),
        .result (ref_out),
        .flags  (ref_flags)
    );

    // Stage 1: capture the observed transaction alongside its expected values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid     <= 1'b0;
            s1_out       <= 4'd0;
            s1_exp_out   <= 4'd0;
            s1_flags     <= '0;
            s1_exp_flags <= '0;
`ifdef ALU_CHK_FIRST_ERR_EN
            s1_a         <= 4'd0;
            s1_b         <= 4'd0;
            s1_sel       <= 2'd0;
`endif
        end else if (clear) begin
            s1_valid     <= 1'b0;
            s1_out       <= 4'd0;
            s1_exp_out   <= 4'd0;
            s1_flags     <= '0;
            s1_exp_flags <= '0;
`ifdef ALU_CHK_FIRST_ERR_EN
            s1_a         <= 4'd0;
            s1_b         <= 4'd0;
            s1_sel       <= 2'd0;
`endif
        end else begin
            s1_valid <= transfer;
            if (transfer) begin
                s1_out       <= out;
                s1_exp_out   <= ref_out;
                s1_flags     <= in_flags;
                s1_exp_flags <= ref_flags;
`ifdef ALU_CHK_FIRST_ERR_EN
                s1_a         <= a;
                s1_b         <= b;
                s1_sel       <= select;
`endif
            end
        end
    end

    always_comb begin
        mismatch                = '0;
        mismatch[MASK_RESULT]   = |(s1_out ^ s1_exp_out);
        mismatch[MASK_ZERO]     = s1_flags.zero     ^ s1_exp_flags.zero;
        mismatch[MASK_CARRY]    = s1_flags.carry    ^ s1_exp_flags.carry;
        mismatch[MASK_SIGN]     = s1_flags.sign     ^ s1_exp_flags.sign;
        mismatch[MASK_PARITY]   = s1_flags.parity   ^ s1_exp_flags.parity;
        mismatch[MASK_OVERFLOW] = s1_flags.overflow ^ s1_exp_flags.overflow;
    end

    assign is_err = s1_valid && (mismatch != '0);

    // Stage 2: statistics and FSM; a halted checker still drains its in-flight transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txn_count <= '0;
            err_count <= '0;
            err_flag  <= 1'b0;
            last_mask <= 6'd0;
            cur_state <= IDLE;
        end else if (clear) begin
            txn_count <= '0;
            err_count <= '0;
            err_flag  <= 1'b0;
            last_mask <= 6'd0;
            cur_state <= IDLE;
        end else if (s1_valid) begin
            last_mask <= mismatch;
            if (txn_count != CNT_MAX) txn_count <= txn_count + CNT_ONE;
            if (is_err) begin
                if (err_count != CNT_MAX) err_count <= err_count + CNT_ONE;
                err_flag <= 1'b1;
                if (cur_state == IDLE || cur_state == PASS)
                    cur_state <= STOP_ON_ERR ? HALT : FAIL;
            end else if (cur_state == IDLE) begin
                cur_state <= PASS;
            end
        end
    end

`ifdef ALU_CHK_FIRST_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_a    <= 4'd0;
            first_b    <= 4'd0;
            first_sel  <= 2'd0;
            first_out  <= 4'd0;
            first_exp  <= 4'd0;
            first_mask <= 6'd0;
            first_idx  <= '0;
        end else if (clear) begin
            first_a    <= 4'd0;
            first_b    <= 4'd0;
            first_sel  <= 2'd0;
            first_out  <= 4'd0;
            first_exp  <= 4'd0;
            first_mask <= 6'd0;
            first_idx  <= '0;
        end else if (is_err && !err_flag) begin
            first_a    <= s1_a;
            first_b    <= s1_b;
            first_sel  <= s1_sel;
            first_out  <= s1_out;
            first_exp  <= s1_exp_out;
            first_mask <= mismatch;
            first_idx  <= txn_count;
        end
    end
`endif

endmodule

// File: tb/tb_alu_checker.sv
// Bench for alu_checker: three instances (default, STOP_ON_ERR=1, CNT_W=4) share one stimulus
// stream and are scored every cycle against an arithmetic reference model.
module tb_alu_checker;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] sel;
        logic [3:0] out;
        logic [4:0] flg;
        logic [5:0] exp_mask;
        int         exp_err;
        int         exp_state;
    } vec_t;

    typedef struct {
        int txn, err, flag, mask, state;
        int pend, pmask, pa, pb, psel, pout, pexp;
        int fa, fb, fsel, fout, fexp, fmask, fidx;
    } mdl_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  a = 4'd0;
    logic [3:0]  b = 4'd0;
    logic [1:0]  sel = 2'd0;
    logic [3:0]  res = 4'd0;
    logic [4:0]  flg = 5'd0;

    logic [2:0]  rdy;
    logic [2:0]  eflag;
    logic [5:0]  lmask [3];
    logic [1:0]  st [3];
    logic [15:0] txn0, err0, txn1, err1;
    logic [3:0]  txn2, err2;
`ifdef ALU_CHK_FIRST_ERR_EN
    logic [3:0]  fa [3];
    logic [3:0]  fb [3];
    logic [1:0]  fsel [3];
    logic [3:0]  fout [3];
    logic [3:0]  fexp [3];
    logic [5:0]  fmask [3];
    logic [15:0] fidx0, fidx1;
    logic [3:0]  fidx2;
`endif

    int   total = 0;
    int   bad = 0;
    mdl_t mdl [3];
    vec_t tab [8];

    always #5 clk = ~clk;

    alu_checker #(.CNT_W(16), .STOP_ON_ERR(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(rdy[0]),
        .a(a), .b(b), .select(sel), .out(res),
        .zero(flg[4]), .carry(flg[3]), .sign(flg[2]), .parity(flg[1]), .overflow(flg[0]),
        .txn_count(txn0), .err_count(err0), .err_flag(eflag[0]), .last_mask(lmask[0]),
`ifdef ALU_CHK_FIRST_ERR_EN
        .first_a(fa[0]), .first_b(fb[0]), .first_sel(fsel[0]), .first_out(fout[0]),
        .first_exp(fexp[0]), .first_mask(fmask[0]), .first_idx(fidx0),
`endif
        .state(st[0])
    );

    alu_checker #(.CNT_W(16), .STOP_ON_ERR(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(rdy[1]),
        .a(a), .b(b), .select(sel), .out(res),
        .zero(flg[4]), .carry(flg[3]), .sign(flg[2]), .parity(flg[1]), .overflow(flg[0]),
        .txn_count(txn1), .err_count(err1), .err_flag(eflag[1]), .last_mask(lmask[1]),
`ifdef ALU_CHK_FIRST_ERR_EN
        .first_a(fa[1]), .first_b(fb[1]), .first_sel(fsel[1]), .first_out(fout[1]),
        .first_exp(fexp[1]), .first_mask(fmask[1]), .first_idx(fidx1),
`endif
        .state(st[1])
    );

    alu_checker #(.CNT_W(4), .STOP_ON_ERR(1'b0)) dut2 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(rdy[2]),
        .a(a), .b(b), .select(sel), .out(res),
        .zero(flg[4]), .carry(flg[3]), .sign(flg[2]), .parity(flg[1]), .overflow(flg[0]),
        .txn_count(txn2), .err_count(err2), .err_flag(eflag[2]), .last_mask(lmask[2]),
`ifdef ALU_CHK_FIRST_ERR_EN
        .first_a(fa[2]), .first_b(fb[2]), .first_sel(fsel[2]), .first_out(fout[2]),
        .first_exp(fexp[2]), .first_mask(fmask[2]), .first_idx(fidx2),
`endif
        .state(st[2])
    );

    // Integer-arithmetic ALU: returns {result[3:0], zero, carry, sign, parity, overflow}.
    function automatic logic [8:0] ref_alu(input int ai, input int bi, input int op);
        int r, sa, sb, sr;
        logic c, v;
        logic [3:0] q;
        sa = (ai > 7) ? ai - 16 : ai;
        sb = (bi > 7) ? bi - 16 : bi;
        r = 0; c = 1'b0; v = 1'b0;
        case (op)
            0: begin r = ai + bi; c = (r > 15); sr = sa + sb; v = (sr > 7) || (sr < -8); end
            1: begin r = ai - bi; c = (ai < bi); sr = sa - sb; v = (sr > 7) || (sr < -8); end
            2: r = ai & bi;
            default: r = ai | bi;
        endcase
        q = 4'(r & 15);
        return {q, (q == 4'd0), c, q[3], ($countones(q) % 2 == 1), v};
    endfunction

    function automatic int calc_mask(input int ai, input int bi, input int op,
                                     input logic [3:0] o, input logic [4:0] f);
        logic [8:0] e;
        int m;
        e = ref_alu(ai, bi, op);
        m = 0;
        if (e[8:5] != o)  m += 1;
        if (e[4] != f[4]) m += 2;
        if (e[3] != f[3]) m += 4;
        if (e[2] != f[2]) m += 8;
        if (e[1] != f[1]) m += 16;
        if (e[0] != f[0]) m += 32;
        return m;
    endfunction

    task automatic step_model(input int i);
        int cmax, nxt;
        logic [8:0] e;
        bit accept;
        cmax = (i == 2) ? 15 : 65535;
        if (!rst_n || clear) begin
            mdl[i] = '{default: 0};
            return;
        end
        accept = in_valid && (mdl[i].state != 3);
        if (mdl[i].pend != 0) begin
            mdl[i].mask = mdl[i].pmask;
            if (mdl[i].pmask != 0) begin
                if (mdl[i].flag == 0) begin
                    mdl[i].fa = mdl[i].pa;     mdl[i].fb = mdl[i].pb;
                    mdl[i].fsel = mdl[i].psel; mdl[i].fout = mdl[i].pout;
                    mdl[i].fexp = mdl[i].pexp; mdl[i].fmask = mdl[i].pmask;
                    mdl[i].fidx = mdl[i].txn;
                end
                if (mdl[i].err < cmax) mdl[i].err++;
                mdl[i].flag = 1;
                mdl[i].state = (i == 1) ? 3 : 2;
            end else if (mdl[i].state == 0) begin
                mdl[i].state = 1;
            end
            nxt = mdl[i].txn + 1;
            if (nxt <= cmax) mdl[i].txn = nxt;
        end
        mdl[i].pend = accept ? 1 : 0;
        if (accept) begin
            e = ref_alu(int'(a), int'(b), int'(sel));
            mdl[i].pmask = calc_mask(int'(a), int'(b), int'(sel), res, flg);
            mdl[i].pa = int'(a); mdl[i].pb = int'(b); mdl[i].psel = int'(sel);
            mdl[i].pout = int'(res); mdl[i].pexp = int'(e[8:5]);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 3; i++) step_model(i);
    end

    task automatic cmp(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic checkOutput();
        int txn_a [3];
        int err_a [3];
        txn_a = '{int'(txn0), int'(txn1), int'(txn2)};
        err_a = '{int'(err0), int'(err1), int'(err2)};
        for (int i = 0; i < 3; i++) begin
            cmp($sformatf("d%0d_ready", i), int'(rdy[i]), (mdl[i].state != 3 && !clear) ? 1 : 0);
            cmp($sformatf("d%0d_txn", i), txn_a[i], mdl[i].txn);
            cmp($sformatf("d%0d_err", i), err_a[i], mdl[i].err);
            cmp($sformatf("d%0d_flag", i), int'(eflag[i]), mdl[i].flag);
            cmp($sformatf("d%0d_mask", i), int'(lmask[i]), mdl[i].mask);
            cmp($sformatf("d%0d_state", i), int'(st[i]), mdl[i].state);
        end
`ifdef ALU_CHK_FIRST_ERR_EN
        cmp("d0_first_a", int'(fa[0]), mdl[0].fa);
        cmp("d0_first_b", int'(fb[0]), mdl[0].fb);
        cmp("d0_first_sel", int'(fsel[0]), mdl[0].fsel);
        cmp("d0_first_out", int'(fout[0]), mdl[0].fout);
        cmp("d0_first_exp", int'(fexp[0]), mdl[0].fexp);
        cmp("d0_first_mask", int'(fmask[0]), mdl[0].fmask);
        cmp("d0_first_idx", int'(fidx0), mdl[0].fidx);
`endif
    endtask

    always @(negedge clk) begin
        #2;
        checkOutput();
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        a = v.a; b = v.b; sel = v.sel; res = v.out; flg = v.flg;
        in_valid = 1'b1;
    endtask

    task automatic pulse_clear();
        in_valid = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        logic [8:0] e;
        vec_t rv;
        //          a        b        sel    out      {z,c,s,p,v} mask        err state
        tab[0] = '{4'b0111, 4'b0001, 2'b00, 4'b1000, 5'b00111, 6'b000000, 0, 1};
        tab[1] = '{4'b0000, 4'b0001, 2'b01, 4'b1111, 5'b01100, 6'b000000, 0, 1};
        tab[2] = '{4'b1010, 4'b0101, 2'b10, 4'b0000, 5'b10000, 6'b000000, 0, 1};
        tab[3] = '{4'b0011, 4'b0011, 2'b00, 4'b0110, 5'b00010, 6'b010000, 1, 2};
        tab[4] = '{4'b1100, 4'b0011, 2'b11, 4'b1110, 5'b00100, 6'b000001, 2, 2};
        tab[5] = '{4'b1000, 4'b0001, 2'b01, 4'b0111, 5'b00000, 6'b110000, 3, 2};
        tab[6] = '{4'b1111, 4'b0001, 2'b00, 4'b0000, 5'b11000, 6'b000000, 3, 2};
        tab[7] = '{4'b1111, 4'b0001, 2'b00, 4'b0000, 5'b00000, 6'b000110, 4, 2};

        tick();
        tick();
        cmp("reset_state", int'(st[0]), 0);
        cmp("reset_txn", int'(txn0), 0);
        rst_n = 1'b1;
        #1;
        cmp("reset_ready", int'(rdy[0]), 1);

        foreach (tab[k]) begin
            applyStimulus(tab[k]);
            tick();
            in_valid = 1'b0;
            tick();
            cmp($sformatf("vec%0d_mask", k), int'(lmask[0]), int'(tab[k].exp_mask));
            cmp($sformatf("vec%0d_txn", k), int'(txn0), k + 1);
            cmp($sformatf("vec%0d_err", k), int'(err0), tab[k].exp_err);
            cmp($sformatf("vec%0d_state", k), int'(st[0]), tab[k].exp_state);
        end
        cmp("table_err_flag", int'(eflag[0]), 1);
`ifdef ALU_CHK_FIRST_ERR_EN
        cmp("first_idx", int'(fidx0), 3);
        cmp("first_mask", int'(fmask[0]), 6'b010000);
        cmp("first_exp", int'(fexp[0]), 6);
`endif

        // Halting instance: error on the third of a back-to-back stream.
        pulse_clear();
        applyStimulus(tab[0]); tick();
        applyStimulus(tab[1]); tick();
        applyStimulus(tab[3]); tick();
        applyStimulus(tab[6]); tick();
        cmp("halt_ready_low", int'(rdy[1]), 0);
        cmp("halt_state", int'(st[1]), 3);
        applyStimulus(tab[6]); tick();
        cmp("halt_txn_inflight", int'(txn1), 4);
        cmp("halt_err", int'(err1), 1);
        in_valid = 1'b0;
        tick();
        cmp("halt_txn_hold", int'(txn1), 4);
        cmp("nohalt_txn", int'(txn0), 5);
        pulse_clear();
        #1;
        cmp("clear_state", int'(st[1]), 0);
        cmp("clear_txn", int'(txn1), 0);
        cmp("clear_ready", int'(rdy[1]), 1);

        // Saturation on the 4-bit instance.
        for (int k = 0; k < 20; k++) begin
            applyStimulus(tab[3]);
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        cmp("sat_txn", int'(txn2), 15);
        cmp("sat_err", int'(err2), 15);
        cmp("wide_txn", int'(txn0), 20);

        // Reset between transfer and compare.
        applyStimulus(tab[0]);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        cmp("rst_txn", int'(txn0), 0);
        cmp("rst_err", int'(err0), 0);
        cmp("rst_flag", int'(eflag[0]), 0);
        cmp("rst_mask", int'(lmask[0]), 0);
        cmp("rst_state", int'(st[0]), 0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        cmp("rst_no_inflight", int'(txn0), 0);
        cmp("rst_idle", int'(st[0]), 0);

        // Randomized traffic with occasional single-bit corruption and clears.
        for (int k = 0; k < 400; k++) begin
            rv.a = 4'($urandom_range(15));
            rv.b = 4'($urandom_range(15));
            rv.sel = 2'($urandom_range(3));
            e = ref_alu(int'(rv.a), int'(rv.b), int'(rv.sel));
            if ($urandom_range(3) == 0) e = e ^ (9'd1 << $urandom_range(8));
            rv.out = e[8:5];
            rv.flg = e[4:0];
            applyStimulus(rv);
            in_valid = ($urandom_range(3) != 0);
            clear = ($urandom_range(39) == 0);
            tick();
        end
        in_valid = 1'b0;
        clear = 1'b0;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
